// File: rtl/calc_fsm_seq.sv
// calc_fsm_seq: four-mode sequential calculator with debounced buttons, iterative mul/div and BCD output
module calc_fsm_seq_deb #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clock,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic s1, s2, lvl;
    logic [CW-1:0] cnt;
    // two-flop synchroniser, then accept a new level after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            press <= 1'b0;
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                lvl   <= s2;
                cnt   <= '0;
                press <= !s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module calc_fsm_seq #(
    parameter int WIDTH      = 4,
    parameter int DIGITS     = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  btn_reset,
    input  logic                  btn_modo,
    input  logic                  btn_res,
    input  logic [WIDTH-1:0]      op_a,
    input  logic [WIDTH-1:0]      op_b,
    output logic [3:0]            led_modo,
    output logic                  led_alerta,
    output logic                  busy,
    output logic                  result_valid,
    output logic [4*DIGITS-1:0]   result_bcd
);
    localparam int W2 = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(W2 + 1);

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam longint MAX_OP = (longint'(1) << WIDTH) - 1;

    generate
        if (pow10(DIGITS) <= MAX_OP * MAX_OP) begin : g_bad_digits
            $error("calc_fsm_seq: DIGITS too small to hold the largest product");
        end
        if (DEB_CYCLES < 2) begin : g_bad_deb
            $error("calc_fsm_seq: DEB_CYCLES must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;
    typedef enum logic [1:0] {M_ADD, M_SUB, M_MUL, M_DIV} mode_t;

    state_t            state, state_d;
    mode_t             mode, mode_d, op, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, rem, rem_d;
    logic [W2-1:0]     acc, acc_d, mc, mc_d, bin, bin_d, val;
    logic [BW-1:0]     bcd, bcd_d, adj, bcd_out_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              alert, alert_d, led_d, fin, al, ge;
    logic [WIDTH:0]    r;
    logic [BW+W2-1:0]  dd;
    logic              modo_ev, res_ev;

    calc_fsm_seq_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_modo (
        .clock (clock),
        .rst_n (btn_reset),
        .btn   (btn_modo),
        .press (modo_ev)
    );

    calc_fsm_seq_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_res (
        .clock (clock),
        .rst_n (btn_reset),
        .btn   (btn_res),
        .press (res_ev)
    );

    assign led_modo     = 4'b0001 << mode;
    assign busy         = state != IDLE;
    assign result_valid = state == DONE;

    // next-state and datapath: capture in IDLE, arithmetic in CALC, double-dabble in CONV
    always_comb begin
        state_d   = state;
        mode_d    = mode;
        op_d      = op;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem;
        acc_d     = acc;
        mc_d      = mc;
        bin_d     = bin;
        bcd_d     = bcd;
        cnt_d     = cnt;
        alert_d   = alert;
        bcd_out_d = result_bcd;
        led_d     = led_alerta;
        fin       = 1'b0;
        al        = 1'b0;
        val       = '0;
        r         = {rem, a_q[WIDTH-1]};
        ge        = r >= {1'b0, b_q};
        adj       = bcd;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
        dd = {adj, bin} << 1;
        case (state)
            IDLE: begin
                if (res_ev) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    op_d    = mode;
                    cnt_d   = '0;
                    acc_d   = '0;
                    rem_d   = '0;
                    mc_d    = W2'(op_a);
                    state_d = CALC;
                end else if (modo_ev) begin
                    mode_d = mode_t'(mode + 2'd1);
                end
            end
            CALC: begin
                case (op)
                    M_ADD: begin
                        fin = 1'b1;
                        val = W2'({1'b0, a_q} + {1'b0, b_q});
                    end
                    M_SUB: begin
                        fin = 1'b1;
                        al  = a_q < b_q;
                        val = W2'(a_q >= b_q ? a_q - b_q : b_q - a_q);
                    end
                    M_MUL: begin
                        if (cnt == CW'(WIDTH)) begin
                            fin = 1'b1;
                            val = acc;
                        end else begin
                            acc_d = b_q[0] ? acc + mc : acc;
                            mc_d  = mc << 1;
                            b_d   = b_q >> 1;
                            cnt_d = cnt + CW'(1);
                        end
                    end
                    default: begin
                        if (b_q == '0) begin
                            fin = 1'b1;
                            al  = 1'b1;
                        end else if (cnt == CW'(WIDTH)) begin
                            fin = 1'b1;
                            val = W2'(a_q);
                        end else begin
                            rem_d = ge ? WIDTH'(r - {1'b0, b_q}) : r[WIDTH-1:0];
                            a_d   = (a_q << 1) | WIDTH'(ge);
                            cnt_d = cnt + CW'(1);
                        end
                    end
                endcase
                if (fin) begin
                    bin_d   = val;
                    alert_d = al;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = dd[BW+W2-1:W2];
                bin_d = dd[W2-1:0];
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(W2 - 1)) begin
                    bcd_out_d = dd[BW+W2-1:W2];
                    led_d     = alert;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset is asynchronous so outputs clear without a clock
    always_ff @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            state      <= IDLE;
            mode       <= M_ADD;
            op         <= M_ADD;
            a_q        <= '0;
            b_q        <= '0;
            rem        <= '0;
            acc        <= '0;
            mc         <= '0;
            bin        <= '0;
            bcd        <= '0;
            cnt        <= '0;
            alert      <= 1'b0;
            result_bcd <= '0;
            led_alerta <= 1'b0;
        end else begin
            state      <= state_d;
            mode       <= mode_d;
            op         <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem        <= rem_d;
            acc        <= acc_d;
            mc         <= mc_d;
            bin        <= bin_d;
            bcd        <= bcd_d;
            cnt        <= cnt_d;
            alert      <= alert_d;
            result_bcd <= bcd_out_d;
            led_alerta <= led_d;
        end
    end
endmodule

// File: tb/tb_calc_fsm_seq.sv
// tb_calc_fsm_seq: directed checks of calc_fsm_seq arithmetic, latency, buttons and reset
module tb_calc_fsm_seq;
    localparam int W = 4;
    localparam int D = 4;

    logic            clock = 1'b0;
    logic            btn_reset = 1'b0;
    logic            btn_modo = 1'b1;
    logic            btn_res = 1'b1;
    logic [W-1:0]    op_a = '0;
    logic [W-1:0]    op_b = '0;
    logic [3:0]      led_modo;
    logic            led_alerta;
    logic            busy;
    logic            result_valid;
    logic [4*D-1:0]  result_bcd;
    int              errors = 0;
    int              checks = 0;

    calc_fsm_seq #(.WIDTH(W), .DIGITS(D), .DEB_CYCLES(4)) dut (
        .clock        (clock),
        .btn_reset    (btn_reset),
        .btn_modo     (btn_modo),
        .btn_res      (btn_res),
        .op_a         (op_a),
        .op_b         (op_b),
        .led_modo     (led_modo),
        .led_alerta   (led_alerta),
        .busy         (busy),
        .result_valid (result_valid),
        .result_bcd   (result_bcd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press_modo(input logic [3:0] exp_led, input string tag);
        btn_modo = 1'b0;
        repeat (10) @(negedge clock);
        btn_modo = 1'b1;
        repeat (10) @(negedge clock);
        check(tag, 32'(led_modo), 32'(exp_led));
    endtask

    task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic both,
                       input logic [15:0] eb, input logic ea, input int lat);
        int n, t;
        op_a = a;
        op_b = b;
        btn_res = 1'b0;
        if (both) btn_modo = 1'b0;
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        btn_res = 1'b1;
        btn_modo = 1'b1;
        op_a = ~a;
        op_b = ~b;
        t = 0;
        while (!result_valid && t < 40) begin
            @(negedge clock);
            t++;
        end
        check({tag, " latency"}, 32'(t), 32'(lat - 1));
        check({tag, " bcd"}, 32'(result_bcd), 32'(eb));
        check({tag, " alert"}, 32'(led_alerta), 32'(ea));
        @(negedge clock);
        check({tag, " pulse end"}, {30'd0, busy, result_valid}, 32'd0);
        repeat (10) @(negedge clock);
    endtask

    initial begin
        int n, cnt;
        repeat (3) @(negedge clock);
        check("reset led_modo", 32'(led_modo), 32'h1);
        check("reset alert", 32'(led_alerta), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset valid", 32'(result_valid), 32'h0);
        check("reset bcd", 32'(result_bcd), 32'h0);
        btn_reset = 1'b1;
        repeat (3) @(negedge clock);

        run("add 12+4", 4'd12, 4'd4, 1'b0, 16'h0016, 1'b0, 10);
        check("add led_modo", 32'(led_modo), 32'h1);

        press_modo(4'b0010, "mode sub");
        run("sub 12-4", 4'd12, 4'd4, 1'b0, 16'h0008, 1'b0, 10);
        run("sub 6-14", 4'd6, 4'd14, 1'b0, 16'h0008, 1'b1, 10);
        run("sub 6-6", 4'd6, 4'd6, 1'b0, 16'h0000, 1'b0, 10);

        press_modo(4'b0100, "mode mul");
        run("mul 12*4", 4'd12, 4'd4, 1'b0, 16'h0048, 1'b0, 14);
        run("mul 15*15", 4'd15, 4'd15, 1'b0, 16'h0225, 1'b0, 14);

        press_modo(4'b1000, "mode div");
        run("div 12/4", 4'd12, 4'd4, 1'b0, 16'h0003, 1'b0, 14);
        run("div 12/5", 4'd12, 4'd5, 1'b0, 16'h0002, 1'b0, 14);
        run("div 14/6", 4'd14, 4'd6, 1'b0, 16'h0002, 1'b0, 14);
        run("div 2/0", 4'd2, 4'd0, 1'b0, 16'h0000, 1'b1, 10);
        run("div 12/4 again", 4'd12, 4'd4, 1'b0, 16'h0003, 1'b0, 14);

        // short press below the debounce threshold
        cnt = 0;
        btn_res = 1'b0;
        repeat (3) @(negedge clock);
        btn_res = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (busy) cnt++;
        end
        check("short press busy cycles", 32'(cnt), 32'd0);

        // long hold gives a single result
        op_a = 4'd9;
        op_b = 4'd3;
        cnt = 0;
        btn_res = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (result_valid) cnt++;
        end
        btn_res = 1'b1;
        repeat (20) begin
            @(negedge clock);
            if (result_valid) cnt++;
        end
        check("held press valid count", 32'(cnt), 32'd1);
        check("held press bcd", 32'(result_bcd), 32'h0003);

        // single-cycle glitches never debounce into an event
        cnt = 0;
        repeat (10) begin
            btn_res = 1'b0;
            @(negedge clock);
            if (busy) cnt++;
            btn_res = 1'b1;
            @(negedge clock);
            if (busy) cnt++;
        end
        repeat (20) begin
            @(negedge clock);
            if (busy) cnt++;
        end
        check("glitch busy cycles", 32'(cnt), 32'd0);

        // res and modo pressed again while the divide is in flight
        op_a = 4'd12;
        op_b = 4'd4;
        btn_res = 1'b0;
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        btn_res = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (result_valid) cnt++;
            if (i == 5) begin
                btn_res = 1'b0;
                btn_modo = 1'b0;
            end
            if (i == 14) begin
                btn_res = 1'b1;
                btn_modo = 1'b1;
            end
        end
        check("busy press valid count", 32'(cnt), 32'd1);
        check("busy press bcd", 32'(result_bcd), 32'h0003);
        check("busy press led_modo", 32'(led_modo), 32'h8);

        // simultaneous modo and res in IDLE: divide in the old mode, mode kept
        op_a = 4'd12;
        op_b = 4'd4;
        run("same-cycle modo+res", 4'd12, 4'd4, 1'b1, 16'h0003, 1'b0, 14);
        check("same-cycle led_modo", 32'(led_modo), 32'h8);

        press_modo(4'b0001, "mode wrap add");
        press_modo(4'b0010, "mode sub 2");
        run("sub 6-14 pre-reset", 4'd6, 4'd14, 1'b0, 16'h0008, 1'b1, 10);
        press_modo(4'b0100, "mode mul 2");

        // asynchronous reset in the middle of a multiply
        op_a = 4'd15;
        op_b = 4'd15;
        btn_res = 1'b0;
        n = 0;
        while (!busy && n < 40) begin
            @(negedge clock);
            n++;
        end
        btn_res = 1'b1;
        check("mid-mul busy before reset", 32'(busy), 32'h1);
        repeat (4) @(negedge clock);
        #2 btn_reset = 1'b0;
        #1;
        check("async reset busy", 32'(busy), 32'h0);
        check("async reset valid", 32'(result_valid), 32'h0);
        check("async reset bcd", 32'(result_bcd), 32'h0);
        check("async reset alert", 32'(led_alerta), 32'h0);
        check("async reset led_modo", 32'(led_modo), 32'h1);
        repeat (3) @(negedge clock);
        btn_reset = 1'b1;
        repeat (3) @(negedge clock);
        run("add 2+2 after reset", 4'd2, 4'd2, 1'b0, 16'h0004, 1'b0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_fsm_seq.md
Name: calc_fsm_seq

Overview:
Parametrised, sequential successor to the four-mode switch calculator FSM. Supports four modes: add, sub, mul, div.
- Operands are WIDTH bits wide.
- Buttons are synchronised and debounced internally.
- Multiply and divide are iterative, one bit per cycle.
- The binary result is converted to packed BCD by an iterative double-dabble stage.
- Output feeds the existing 7-segment decoders, one decoder per BCD digit.

Parameters:
- WIDTH, 4, operand width in bits.
- DIGITS, 4, number of BCD result digits. Must satisfy 10^DIGITS > (2^WIDTH-1)^2; elaboration error otherwise.
- DEB_CYCLES, 4, consecutive stable cycles required to accept a button level change (>=2).

Ports:
- clock  in  1  system clock, rising edge.
- btn_reset  in  1  asynchronous active-low reset.
- btn_modo  in  1  active-low mode button, asynchronous to clock.
- btn_res  in  1  active-low "compute" button, asynchronous to clock.
- op_a  in  WIDTH  operand 1 (switch bank 0).
- op_b  in  WIDTH  operand 2 (switch bank 1).
- led_modo  out  4  one-hot mode: bit0 add, bit1 sub, bit2 mul, bit3 div.
- led_alerta  out  1  alert flag for the last result.
- busy  out  1  high while a calculation is in flight.
- result_valid  out  1  one-cycle pulse when result_bcd updates.
- result_bcd  out  4*DIGITS  packed BCD result, digit 0 in bits [3:0].

Behaviour:
- Reset (btn_reset=0, asynchronous, overrides everything, including mid-operation):
  - state=IDLE, mode=add, led_modo=4'b0001.
  - led_alerta=0, busy=0, result_valid=0, result_bcd=0.
  - Debouncers settle to the released (1) level.
- Button conditioning (each button):
  - 2-flop synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised input differs from it for DEB_CYCLES consecutive cycles.
  - A press event is a single-cycle pulse on the debounced 1->0 edge. Holding the button generates no further events.
- States: IDLE -> CALC -> CONV -> DONE -> IDLE.
- IDLE:
  - A modo event advances the mode add->sub->mul->div->add.
  - A res event captures op_a/op_b and the current mode, clears a shift counter, and goes to CALC. busy=1 from the next cycle.
  - Modo and res events in the same cycle: res wins using the pre-advance mode; the modo event is dropped.
- All events outside IDLE are discarded (no queueing). Operand changes after capture have no effect.
- CALC:
  - add: 1 cycle, result = a+b (WIDTH+1 bits).
  - sub: 1 cycle. a>=b gives a-b, alert=0. a<b gives b-a (magnitude), alert=1.
  - mul: WIDTH cycles shift-add, result 2*WIDTH bits, alert=0.
  - div: WIDTH cycles restoring division, quotient only, remainder discarded. If b==0: 1 cycle, result=0, alert=1.
  - All results are zero-extended to 2*WIDTH bits.
- CONV: double-dabble, exactly 2*WIDTH cycles. Each digit nibble >=5 gets +3, then a left shift.
- DONE (1 cycle):
  - result_bcd and led_alerta load together; result_valid=1; busy=0 from the next cycle.
  - led_alerta and result_bcd hold until the next DONE or reset.
- Latency, from the res-event cycle to the result_valid cycle:
  - add/sub/div-by-zero: 2*WIDTH+2 cycles.
  - mul/div: 3*WIDTH+2 cycles.
  - For WIDTH=4: 10 and 14.
- Repeated res with unchanged operands produces an identical result and a new result_valid pulse.
- Mode cannot change while busy.

Test Plan:
1. Add. After reset, op_a=12, op_b=4, press res.
   -> result_bcd=16'h0016, led_alerta=0, result_valid exactly 10 cycles after the event, led_modo=0001.
2. Sub. One modo press (led_modo=0010). 12-4 gives 16'h0008, alert 0. Then 6-14 gives 16'h0008, alert 1. Then 6-6 gives 16'h0000, alert 0.
3. Mul. led_modo=0100. 12*4 gives 16'h0048 with latency 14. 15*15 gives 16'h0225.
4. Div. led_modo=1000.
   - 12/4 gives 0003; 12/5 gives 0002; 14/6 gives 0002.
   - 2/0 gives 0000, alert 1, latency 10.
   - Then 12/4 clears alert to 0.
5. Buttons.
   - btn_res low for DEB_CYCLES-1 cycles: no event.
   - Held low 100 cycles: exactly one result_valid.
   - Bouncing 1-cycle glitches: no extra events.
   - res and modo pressed during busy: ignored, mode unchanged.
   - Same-cycle modo+res in IDLE: computes in the old mode, mode unchanged afterwards.
6. Reset. btn_reset low mid-mul (cycle 5 of CALC): all outputs return to reset values immediately, without waiting for a clock edge. After release, add 2+2 gives 0004.
